// File: rtl/sequencer_pkg.sv
// Shared types for the RV32 multi-cycle sequencer: state encodings, opcode classes, decode helper.
// Pure declarations, no latency or flow control of its own.
package sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_FAULT     = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        CLS_LOAD   = 2'd0,
        CLS_STORE  = 2'd1,
        CLS_BRANCH = 2'd2,
        CLS_WB     = 2'd3
    } op_class_t;

    typedef struct packed {
        logic      legal;
        op_class_t cls;
    } dec_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic dec_t classify(input logic [6:0] op);
        dec_t d;
        d.legal = 1'b1;
        d.cls   = CLS_WB;
        case (op)
            OP_LOAD:   d.cls = CLS_LOAD;
            OP_STORE:  d.cls = CLS_STORE;
            OP_BRANCH: d.cls = CLS_BRANCH;
            OP_IMM, OP_IMM32, OP_REG, OP_REG32, OP_LUI, OP_JAL: d.cls = CLS_WB;
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// 8-bit wait counter; expired is combinational and means one more missed cycle reaches limit.
// Latency: count updates on the edge after cnt_en; clear has priority, no backpressure.
module wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       cnt_en,
    input  logic [7:0] limit,
    output logic       expired
);
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= 8'd0;
        end else if (cnt_en && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Flagged one cycle early so the caller can let a same-cycle ack win.
    assign expired = ({1'b0, cnt} + 9'd1) >= {1'b0, limit};

endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM with retire counter and sticky fault.
// Latency 3-5 cycles per instruction plus memory waits; stalls on imem_ack/dmem_ack, faults on timeout.
module inst_sequencer
    import sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [6:0]  opcode,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        inst_latch_en,
    output logic        dmem_read,
    output logic        dmem_write,
    input  logic        dmem_ack,
    output logic        reg_write_en,
    output logic        pc_en,
    output logic [2:0]  state_out,
    output logic        fault,
    output logic [31:0] instret
);
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    seq_state_t state, state_nxt;
    op_class_t  cls;
    dec_t       dec;
    logic       retire;
    logic       waiting;
    logic       expired;

    assign dec = classify(opcode);

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            ST_IDLE:      if (en) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack)     state_nxt = ST_DECODE;
                else if (expired) state_nxt = ST_FAULT;
            end
            ST_DECODE:    state_nxt = dec.legal ? ST_EXECUTE : ST_FAULT;
            ST_EXECUTE: begin
                case (cls)
                    CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
                    CLS_WB:              state_nxt = ST_WRITEBACK;
                    default:             retire    = 1'b1;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (cls == CLS_LOAD) state_nxt = ST_WRITEBACK;
                    else                 retire    = 1'b1;
                end else if (expired) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_WRITEBACK: retire = 1'b1;
            ST_FAULT:     state_nxt = ST_FAULT;
            default:      state_nxt = ST_IDLE;
        endcase
        if (retire) state_nxt = en ? ST_FETCH : ST_IDLE;
    end

    assign waiting = (state == ST_FETCH && !imem_ack) || (state == ST_MEM && !dmem_ack);

    // Any state change clears the timer, covering every entry into FETCH or MEM.
    wait_timer u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_nxt != state),
        .cnt_en  (waiting),
        .limit   (LIMIT),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cls     <= CLS_LOAD;
            instret <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) cls <= dec.cls;
            if (retire) instret <= instret + 32'd1;
        end
    end

    assign imem_req      = (state == ST_FETCH);
    assign inst_latch_en = imem_req & imem_ack;
    assign dmem_read     = (state == ST_MEM) && (cls == CLS_LOAD);
    assign dmem_write    = (state == ST_MEM) && (cls == CLS_STORE);
    assign reg_write_en  = (state == ST_WRITEBACK);
    assign pc_en         = retire;
    assign fault         = (state == ST_FAULT);
    assign state_out     = state;

endmodule

// File: tb/tb_inst_sequencer.sv
// Table-driven scoreboard bench for inst_sequencer: each row drives one cycle of inputs
// and carries the outputs and retire count expected in that cycle.
module tb_inst_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        imem_req, imem_ack = 1'b0, inst_latch_en;
    logic        dmem_read, dmem_write, dmem_ack = 1'b0;
    logic        reg_write_en, pc_en, fault;
    logic [2:0]  state_out;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        r, e, ia, da;
        logic [6:0]  op;
        logic [9:0]  exp_o;
        logic [31:0] exp_ir;
    } row_t;

    row_t sb[$];

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;
    localparam logic [6:0] IMM = 7'b0010011, RR = 7'b0110011, BAD = 7'b1111111;
    logic [6:0] wb_ops [6] = '{7'b0010011, 7'b0011011, 7'b0110011,
                               7'b0111011, 7'b0110111, 7'b1101111};

    inst_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode),
        .imem_req(imem_req), .imem_ack(imem_ack), .inst_latch_en(inst_latch_en),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_ack(dmem_ack),
        .reg_write_en(reg_write_en), .pc_en(pc_en), .state_out(state_out),
        .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // fl = {imem_req, inst_latch_en, dmem_read, dmem_write, reg_write_en, pc_en, fault}
    task automatic push(input bit r, input bit e, input bit ia, input bit da,
                        input logic [6:0] op, input int st, input logic [6:0] fl,
                        input logic [31:0] ir);
        row_t w;
        w.r = r; w.e = e; w.ia = ia; w.da = da; w.op = op;
        w.exp_o = {3'(st), fl};
        w.exp_ir = ir;
        sb.push_back(w);
    endtask

    task automatic drain();
        row_t w;
        int   n = 0;
        while (sb.size() != 0) begin
            w = sb.pop_front();
            rst = w.r; en = w.e; imem_ack = w.ia; dmem_ack = w.da; opcode = w.op;
            #1;
            check($sformatf("row%0d outputs", n),
                  {22'd0, state_out, imem_req, inst_latch_en, dmem_read, dmem_write,
                   reg_write_en, pc_en, fault}, {22'd0, w.exp_o});
            check($sformatf("row%0d instret", n), instret, w.exp_ir);
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        // Reset held: IDLE, every strobe low, instret 0.
        push(1, 0, 0, 0, 7'd0, 0, 7'b0000000, 0);

        // WB-class instruction, zero-wait: 1,2,3,5,1, then reset mid-FETCH.
        push(0, 1, 0, 0, RR, 0, 7'b0000000, 0);
        push(0, 1, 1, 0, RR, 1, 7'b1100000, 0);
        push(0, 1, 0, 0, RR, 2, 7'b0000000, 0);
        push(0, 1, 0, 0, RR, 3, 7'b0000000, 0);
        push(0, 1, 0, 0, RR, 5, 7'b0000110, 0);
        push(1, 1, 0, 0, RR, 1, 7'b1000000, 1);
        push(0, 0, 0, 0, RR, 0, 7'b0000000, 0);

        // Load with ack after 3 waits; opcode changes after DECODE; en dropped in MEM.
        push(0, 1, 0, 0, LD, 0, 7'b0000000, 0);
        push(0, 1, 1, 0, LD, 1, 7'b1100000, 0);
        push(0, 1, 0, 0, LD, 2, 7'b0000000, 0);
        push(0, 1, 0, 0, BAD, 3, 7'b0000000, 0);
        push(0, 1, 0, 0, BAD, 4, 7'b0010000, 0);
        push(0, 0, 0, 0, BAD, 4, 7'b0010000, 0);
        push(0, 0, 1, 0, BAD, 4, 7'b0010000, 0);
        push(0, 0, 0, 1, BAD, 4, 7'b0010000, 0);
        push(0, 0, 0, 0, BAD, 5, 7'b0000110, 0);
        push(0, 0, 0, 0, BAD, 0, 7'b0000000, 1);
        push(0, 0, 0, 0, BAD, 0, 7'b0000000, 1);

        // Store then branch, with stray acks in the wrong states.
        push(0, 1, 0, 0, ST, 0, 7'b0000000, 1);
        push(0, 1, 1, 0, ST, 1, 7'b1100000, 1);
        push(0, 1, 0, 0, ST, 2, 7'b0000000, 1);
        push(0, 1, 0, 0, ST, 3, 7'b0000000, 1);
        push(0, 1, 1, 0, ST, 4, 7'b0001000, 1);
        push(0, 1, 0, 1, ST, 4, 7'b0001010, 1);
        push(0, 1, 1, 1, BR, 1, 7'b1100000, 2);
        push(0, 1, 0, 0, BR, 2, 7'b0000000, 2);
        push(0, 0, 0, 0, BR, 3, 7'b0000010, 2);
        push(0, 0, 0, 0, BR, 0, 7'b0000000, 3);

        // Every WB-class opcode back to back.
        push(0, 1, 0, 0, wb_ops[0], 0, 7'b0000000, 3);
        for (int i = 0; i < 6; i++) begin
            push(0, 1, 1, 0, wb_ops[i], 1, 7'b1100000, 3 + i);
            push(0, 1, 0, 0, wb_ops[i], 2, 7'b0000000, 3 + i);
            push(0, 1, 0, 0, wb_ops[i], 3, 7'b0000000, 3 + i);
            push(0, (i < 5), 0, 0, wb_ops[i], 5, 7'b0000110, 3 + i);
        end
        push(0, 0, 0, 0, IMM, 0, 7'b0000000, 9);

        // Illegal opcode: sticky FAULT until reset.
        push(0, 1, 0, 0, BAD, 0, 7'b0000000, 9);
        push(0, 1, 1, 0, BAD, 1, 7'b1100000, 9);
        push(0, 1, 0, 0, BAD, 2, 7'b0000000, 9);
        push(0, 1, 1, 1, BAD, 6, 7'b0000001, 9);
        push(0, 1, 1, 1, BR, 6, 7'b0000001, 9);
        push(1, 1, 0, 0, BR, 6, 7'b0000001, 9);
        push(0, 0, 0, 0, BR, 0, 7'b0000000, 0);

        // Fetch timeout after 4 waits, then ack on the 4th wait cycle wins.
        push(0, 1, 0, 0, IMM, 0, 7'b0000000, 0);
        for (int i = 0; i < 4; i++) push(0, 1, 0, 0, IMM, 1, 7'b1000000, 0);
        push(1, 1, 0, 0, IMM, 6, 7'b0000001, 0);
        push(0, 1, 0, 0, IMM, 0, 7'b0000000, 0);
        for (int i = 0; i < 3; i++) push(0, 1, 0, 0, IMM, 1, 7'b1000000, 0);
        push(0, 1, 1, 0, IMM, 1, 7'b1100000, 0);
        push(0, 1, 0, 0, IMM, 2, 7'b0000000, 0);
        push(0, 1, 0, 0, IMM, 3, 7'b0000000, 0);
        push(0, 0, 0, 0, IMM, 5, 7'b0000110, 0);
        push(0, 0, 0, 0, IMM, 0, 7'b0000000, 1);

        // Store with dmem_ack withheld: MEM timeout faults, instret frozen.
        push(0, 1, 0, 0, ST, 0, 7'b0000000, 1);
        push(0, 1, 1, 0, ST, 1, 7'b1100000, 1);
        push(0, 1, 0, 0, ST, 2, 7'b0000000, 1);
        push(0, 1, 0, 0, ST, 3, 7'b0000000, 1);
        for (int i = 0; i < 4; i++) push(0, 1, 0, 0, ST, 4, 7'b0001000, 1);
        push(1, 1, 0, 1, ST, 6, 7'b0000001, 1);
        push(0, 0, 0, 0, ST, 0, 7'b0000000, 0);

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
